// File: rtl/bitcoin_miner_array.sv
// Multi-core double-SHA-256 nonce search: one midstate per job, NUM_CORES interleaved nonce lanes,
// range/abort/target control and a saturating hash counter.

module sha256_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         init_hash,
    input  logic [255:0] hash_in,
    input  logic [511:0] block,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [255:0]      base, st, st_next;
    logic [0:15][31:0] w;
    logic [31:0]       w_next, a, b, c, d, e, f, g, h, t1, t2;
    logic [6:0]        rnd;

    // One compression round per cycle; w is a 16-word sliding schedule window.
    always_comb begin
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[rnd[5:0]] + w[0];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        st_next = {t1 + t2, a, b, c, d + t1, e, f, g};
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            rnd    <= '0;
            base   <= '0;
            st     <= '0;
            w      <= '0;
            digest <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    base <= init_hash ? IV : hash_in;
                    st   <= init_hash ? IV : hash_in;
                    w    <= block;
                    rnd  <= '0;
                    busy <= 1'b1;
                end
            end else if (rnd == 7'd64) begin
                for (int i = 0; i < 8; i++)
                    digest[32*i +: 32] <= base[32*i +: 32] + st[32*i +: 32];
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                st  <= st_next;
                w   <= {w[1:15], w_next};
                rnd <= rnd + 7'd1;
            end
        end
    end
endmodule

module miner_lane #(
    parameter int NUM_CORES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mid_go,
    input  logic         launch,
    input  logic         stop,
    input  logic [31:0]  first,
    input  logic [31:0]  nonce_end,
    input  logic [607:0] header,
    input  logic [255:0] midstate,
    input  logic [255:0] target,
    output logic         active,
    output logic         chk,
    output logic         hit,
    output logic         mid_done,
    output logic         sha_busy,
    output logic [31:0]  nonce,
    output logic [255:0] digest
);
    typedef enum logic [2:0] {C_IDLE, C_MID, C_BLK1, C_BLK2, C_CHK} cstate_t;

    cstate_t      state;
    logic         go, done, init_hash, more;
    logic [511:0] block;
    logic [255:0] rev;
    logic [32:0]  next;

    always_comb begin
        block     = header[607:96];
        init_hash = 1'b1;
        case (state)
            C_BLK1: begin
                block     = {header[95:0], nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24],
                             8'h80, 312'h0, 64'h280};
                init_hash = 1'b0;
            end
            C_BLK2:  block = {digest, 8'h80, 184'h0, 64'h100};
            default: ;
        endcase
    end

    // Target compare works on the digest in Bitcoin display (byte-reversed) order.
    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++)
            rev[8*i +: 8] = digest[255-8*i -: 8];
    end

    assign next     = {1'b0, nonce} + 33'(NUM_CORES);
    assign more     = next <= {1'b0, nonce_end};
    assign chk      = state == C_CHK;
    assign hit      = chk && (rev < target);
    assign active   = state != C_IDLE;
    assign mid_done = (state == C_MID) && done;

    sha256_core u_sha (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (go),
        .init_hash (init_hash),
        .hash_in   (midstate),
        .block     (block),
        .busy      (sha_busy),
        .done      (done),
        .digest    (digest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= C_IDLE;
            go    <= 1'b0;
            nonce <= '0;
        end else begin
            go <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (mid_go) begin
                        state <= C_MID;
                        go    <= 1'b1;
                    end else if (launch) begin
                        nonce <= first;
                        state <= C_BLK1;
                        go    <= 1'b1;
                    end
                end
                C_MID:  if (done) state <= C_IDLE;
                C_BLK1: begin
                    if (done) begin
                        state <= stop ? C_IDLE : C_BLK2;
                        go    <= !stop;
                    end
                end
                C_BLK2: if (done) state <= C_CHK;
                default: begin
                    if (!hit && !stop && more) begin
                        nonce <= next[31:0];
                        state <= C_BLK1;
                        go    <= 1'b1;
                    end else begin
                        state <= C_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

module bitcoin_miner_array #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [639:0]     header_template,
    input  logic [255:0]     target,
    input  logic [31:0]      nonce_start,
    input  logic [31:0]      nonce_end,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             aborted,
    output logic [31:0]      nonce_out,
    output logic [255:0]     hash_out,
    output logic [CNT_W-1:0] hash_count
);
    typedef enum logic [2:0] {S_IDLE, S_MID, S_RUN, S_DRAIN, S_FOUND, S_EXH, S_ABORT} state_t;

    state_t                         state, outcome;
    logic [607:0]                   hdr_r;
    logic [255:0]                   tgt_r, midstate, win_hash;
    logic [31:0]                    nstart_r, nend_r, win_nonce;
    logic                           mid_go, launch_r, any_hit, stop, unused_hdr;
    logic [4:0]                     pop;
    logic [CNT_W:0]                 cnt_sum;
    logic [NUM_CORES-1:0]           lane_active, lane_chk, lane_hit, lane_mid_done, lane_sha_busy;
    logic [NUM_CORES-1:0][31:0]     lane_nonce;
    logic [NUM_CORES-1:0][255:0]    lane_digest;

    // Nonce bytes of the template are replaced per lane, so they are never stored.
    assign unused_hdr = ^header_template[31:0];

    // Scan from the top so the lowest-indexed hitting lane is left as the winner.
    always_comb begin
        any_hit   = 1'b0;
        win_nonce = '0;
        win_hash  = '0;
        pop       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (lane_hit[k]) begin
                any_hit   = 1'b1;
                win_nonce = lane_nonce[k];
                win_hash  = lane_digest[k];
            end
            pop = pop + 5'(lane_chk[k]);
        end
    end

    assign stop    = (state != S_RUN) || abort || any_hit;
    assign cnt_sum = {1'b0, hash_count} + (CNT_W + 1)'(pop);

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
        logic [32:0] first33;
        assign first33 = {1'b0, nstart_r} + 33'(k);

        miner_lane #(.NUM_CORES(NUM_CORES)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .mid_go    ((k == 0) ? mid_go : 1'b0),
            .launch    (launch_r && !abort && (first33 <= {1'b0, nend_r})),
            .stop      (stop),
            .first     (first33[31:0]),
            .nonce_end (nend_r),
            .header    (hdr_r),
            .midstate  (midstate),
            .target    (tgt_r),
            .active    (lane_active[k]),
            .chk       (lane_chk[k]),
            .hit       (lane_hit[k]),
            .mid_done  (lane_mid_done[k]),
            .sha_busy  (lane_sha_busy[k]),
            .nonce     (lane_nonce[k]),
            .digest    (lane_digest[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            outcome    <= S_EXH;
            hdr_r      <= '0;
            tgt_r      <= '0;
            nstart_r   <= '0;
            nend_r     <= '0;
            midstate   <= '0;
            mid_go     <= 1'b0;
            launch_r   <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            aborted    <= 1'b0;
            nonce_out  <= '0;
            hash_out   <= '0;
            hash_count <= '0;
        end else begin
            mid_go   <= 1'b0;
            launch_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hdr_r      <= header_template[639:32];
                        tgt_r      <= target;
                        nstart_r   <= nonce_start;
                        nend_r     <= nonce_end;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        aborted    <= 1'b0;
                        nonce_out  <= '0;
                        hash_out   <= '0;
                        hash_count <= '0;
                        if (nonce_start > nonce_end) begin
                            outcome <= S_EXH;
                            state   <= S_DRAIN;
                        end else begin
                            state  <= S_MID;
                            mid_go <= 1'b1;
                        end
                    end
                end
                S_MID: begin
                    if (abort) begin
                        outcome <= S_ABORT;
                        state   <= S_DRAIN;
                    end else if (|lane_mid_done) begin
                        midstate <= lane_digest[0];
                        launch_r <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    hash_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                    if (any_hit) begin
                        nonce_out <= win_nonce;
                        hash_out  <= win_hash;
                        outcome   <= S_FOUND;
                        state     <= S_DRAIN;
                    end else if (abort) begin
                        outcome <= S_ABORT;
                        state   <= S_DRAIN;
                    end else if (!launch_r && lane_active == '0) begin
                        outcome <= S_EXH;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (lane_active == '0 && lane_sha_busy == '0) begin
                        busy      <= 1'b0;
                        found     <= outcome == S_FOUND;
                        exhausted <= outcome == S_EXH;
                        aborted   <= outcome == S_ABORT;
                        state     <= outcome;
                    end
                end
                default: if (!start) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcoin_miner_array.sv
// Scoreboard bench: jobs push their expected outcome, a monitor pops and checks at each job completion.

module tb_bitcoin_miner_array;
    logic         clk = 1'b0;
    logic         rst_n, start, abort;
    logic [639:0] header_template;
    logic [255:0] target;
    logic [31:0]  nonce_start, nonce_end;
    logic         busy, found, exhausted, aborted;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out;
    logic [47:0]  hash_count;

    typedef struct {
        int           id;
        logic [2:0]   flags;  // {found, exhausted, aborted}
        bit           chk_nonce;
        logic [31:0]  nonce;
        bit           chk_hash;
        logic [255:0] hash;
        bit           chk_cnt;
        logic [47:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    bitcoin_miner_array #(.NUM_CORES(4), .CNT_W(48)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .header_template (header_template),
        .target          (target),
        .nonce_start     (nonce_start),
        .nonce_end       (nonce_end),
        .busy            (busy),
        .found           (found),
        .exhausted       (exhausted),
        .aborted         (aborted),
        .nonce_out       (nonce_out),
        .hash_out        (hash_out),
        .hash_count      (hash_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [2:0] fl, input bit cn, input logic [31:0] n,
                                input bit ch, input logic [255:0] hs, input bit cc, input logic [47:0] c);
        exp_t e;
        e.id = id; e.flags = fl; e.chk_nonce = cn; e.nonce = n;
        e.chk_hash = ch; e.hash = hs; e.chk_cnt = cc; e.cnt = c;
        return e;
    endfunction

    task automatic issue(input logic [639:0] h, input logic [255:0] t, input logic [31:0] s,
                         input logic [31:0] en, input bit push, input exp_t e);
        @(negedge clk);
        if (push) exp_q.push_back(e);
        header_template = h; target = t; nonce_start = s; nonce_end = en; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", nm, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: a job is complete on the first sample with busy low after it was seen high.
    initial begin
        bit   armed;
        exp_t e;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) armed = 1'b0;
            else if (busy) armed = 1'b1;
            else if (armed) begin
                armed = 1'b0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: flags %b with no job expected", {found, exhausted, aborted});
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("job%0d_flags", e.id), 256'({found, exhausted, aborted}), 256'(e.flags));
                    if (e.chk_nonce) check($sformatf("job%0d_nonce", e.id), 256'(nonce_out), 256'(e.nonce));
                    if (e.chk_hash)  check($sformatf("job%0d_hash", e.id), hash_out, e.hash);
                    if (e.chk_cnt)   check($sformatf("job%0d_count", e.id), 256'(hash_count), 256'(e.cnt));
                end
            end
        end
    end

    initial begin
        logic [639:0] gen_hdr;
        logic [255:0] gen_tgt, ones, gen_hash;
        exp_t         none;

        gen_hdr  = {32'h01000000, 256'h0,
                    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
                    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
        gen_tgt  = 256'hFFFF;
        gen_tgt  = gen_tgt << 208;
        ones     = '1;
        gen_hash = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
        none     = mk(0, 3'b000, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        header_template = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 256'({busy, found, exhausted, aborted, nonce_out, hash_count}), 256'h0);
        check("reset_hash_out", hash_out, 256'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Genesis block: the real nonce is the fifth in range, i.e. core 0 in round two.
        issue(gen_hdr, gen_tgt, 32'h7C2BAC19, 32'h7C2BAC21, 1,
              mk(1, 3'b100, 1, 32'h7C2BAC1D, 1, gen_hash, 0, 0));
        wait_idle("genesis", 5000);

        // Unreachable target; inputs and start are wiggled mid-job and must be ignored.
        issue(gen_hdr, '0, 32'd0, 32'd9, 1, mk(2, 3'b010, 0, 0, 0, 0, 1, 48'd10));
        repeat (5) @(negedge clk);
        nonce_end = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("exh_0_9", 5000);

        // Idle abort must not touch flags held from the previous job.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort", 256'({busy, found, exhausted, aborted}), 256'(4'b0010));

        // Every nonce hits; all four cores tie and core 0 wins.
        issue(gen_hdr, ones, 32'd5, 32'd100, 1, mk(3, 3'b100, 1, 32'd5, 0, 0, 1, 48'd4));
        wait_idle("tie", 5000);

        // Top of nonce space: only two cores launch and nothing wraps to 0.
        issue(gen_hdr, '0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, mk(4, 3'b010, 0, 0, 0, 0, 1, 48'd2));
        wait_idle("top_range", 5000);

        // Empty range.
        issue(gen_hdr, '0, 32'd20, 32'd10, 1, mk(5, 3'b010, 0, 0, 0, 0, 1, 48'd0));
        wait_idle("empty_range", 100);

        // Abort mid-job; the array must keep busy high while draining.
        issue(gen_hdr, '0, 32'd0, 32'd1000, 1, mk(6, 3'b001, 0, 0, 0, 0, 0, 0));
        repeat (48) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_drain_busy", 256'(busy), 256'(1'b1));
        wait_idle("abort", 5000);

        issue(gen_hdr, '0, 32'd0, 32'd3, 1, mk(7, 3'b010, 0, 0, 0, 0, 1, 48'd4));
        wait_idle("restart", 5000);

        // Asynchronous reset in the middle of a running job.
        issue(gen_hdr, '0, 32'd0, 32'd1000, 0, none);
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 256'({busy, found, exhausted, aborted, nonce_out, hash_count}), 256'h0);
        check("async_reset_hash", hash_out, 256'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(gen_hdr, '0, 32'd0, 32'd3, 1, mk(8, 3'b010, 0, 0, 0, 0, 1, 48'd4));
        wait_idle("post_reset", 5000);

        check("queue_empty", 256'(exp_q.size()), 256'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
